regfile_dump_engine: RTL and testbench

REGFILE_DUMP_ENGINE -- requirements
Module: regfile_dump_engine

---
 rtl/regdump_pkg.sv | 26 ++
 rtl/regdump_xor_acc.sv | 26 ++
 rtl/regfile_dump_engine.sv | 156 +++++++++++++++
 tb/tb_regfile_dump_engine.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regdump_pkg.sv
// Shared types and default sizes for the register-file dump engine.
// REGDUMP_CHECKSUM_EN adds the checksum state to the FSM encoding.
package regdump_pkg;

  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_DATA_W   = 32;

`ifdef REGDUMP_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_SEND,
    ST_CHK,
    ST_DONE
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_SEND,
    ST_DONE
  } state_t;
`endif

endpackage

// File: rtl/regdump_xor_acc.sv
// XOR accumulator over transferred dump beats.
// Only instantiated when REGDUMP_CHECKSUM_EN is defined.
module regdump_xor_acc
  import regdump_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] acc
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc ^ din;
    end
  end

endmodule

// File: rtl/regfile_dump_engine.sv
// Streams every register of a register file out as valid/ready beats.
// REGDUMP_CHECKSUM_EN appends an XOR checksum beat after the last register.
module regfile_dump_engine
  import regdump_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rf_read_addr,
  input  logic [DATA_W-1:0] rf_read_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic [ADDR_W-1:0] dump_index,
  output logic              dump_last,
  output logic              busy,
  output logic              done
);

  state_t state_q, state_d;

  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic              last_q, last_d;
  logic              valid_q, valid_d;
  logic              is_last;
  logic              xfer;

  assign is_last = (idx_q == ADDR_W'(NUM_REGS - 1));
  assign xfer    = valid_q & dump_ready;

`ifdef REGDUMP_CHECKSUM_EN
  logic [DATA_W-1:0] acc;
  logic              acc_clr;
  logic              acc_en;

  regdump_xor_acc #(
    .DATA_W(DATA_W)
  ) u_acc (
    .clk  (clk),
    .rst  (rst),
    .clear(acc_clr),
    .en   (acc_en),
    .din  (data_q),
    .acc  (acc)
  );
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      index_q <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      index_q <= index_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    index_d = index_q;
    last_d  = last_q;
    valid_d = valid_q;
`ifdef REGDUMP_CHECKSUM_EN
    acc_clr = 1'b0;
    acc_en  = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d   = '0;
          state_d = ST_READ;
`ifdef REGDUMP_CHECKSUM_EN
          acc_clr = 1'b1;
`endif
        end
      end
      ST_READ: begin
        // Register 0 is hard-wired zero, whatever the array returns
        data_d  = (idx_q == '0) ? '0 : rf_read_data;
        index_d = idx_q;
        valid_d = 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
        last_d  = 1'b0;
`else
        last_d  = is_last;
`endif
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (xfer) begin
          valid_d = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
          acc_en  = 1'b1;
`endif
          if (!is_last) begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = ST_READ;
          end else begin
`ifdef REGDUMP_CHECKSUM_EN
            state_d = ST_CHK;
`else
            state_d = ST_DONE;
`endif
          end
        end
      end
`ifdef REGDUMP_CHECKSUM_EN
      ST_CHK: begin
        // First cycle loads the finished checksum, then wait for accept
        if (!valid_q) begin
          data_d  = acc;
          index_d = '0;
          last_d  = 1'b1;
          valid_d = 1'b1;
        end else if (dump_ready) begin
          valid_d = 1'b0;
          state_d = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        last_d  = 1'b0;
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign rf_read_addr = idx_q;
  assign dump_valid   = valid_q;
  assign dump_data    = data_q;
  assign dump_index   = index_q;
  assign dump_last    = last_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);

endmodule

// File: tb/tb_regfile_dump_engine.sv
// Scoreboard bench for regfile_dump_engine.
// Honours REGDUMP_CHECKSUM_EN for the extra checksum beat.
module tb_regfile_dump_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  rf_read_addr;
  logic [31:0] rf_read_data;
  logic        dump_valid;
  logic        dump_ready;
  logic [31:0] dump_data;
  logic [4:0]  dump_index;
  logic        dump_last;
  logic        busy;
  logic        done;

  logic [31:0] rf [32];

  typedef struct {
    logic [31:0] d;
    logic [4:0]  i;
    logic        l;
  } beat_t;

  beat_t exp_q[$];

  int n_cmp = 0;
  int n_mis = 0;
  int beat_cnt = 0;
  int done_cnt = 0;
  int n_beats;

  always #5 clk = ~clk;

  assign rf_read_data = rf[rf_read_addr];

  regfile_dump_engine dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .rf_read_addr(rf_read_addr),
    .rf_read_data(rf_read_data),
    .dump_valid  (dump_valid),
    .dump_ready  (dump_ready),
    .dump_data   (dump_data),
    .dump_index  (dump_index),
    .dump_last   (dump_last),
    .busy        (busy),
    .done        (done)
  );

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: a beat transfers at the next rising edge
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (rst && done && dump_valid)
      check("valid_in_done", 1, 0);
    if (rst && dump_valid && dump_ready) begin
      beat_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {dump_data, dump_index, dump_last}, 0);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check("beat", {26'd0, dump_data, dump_index, dump_last},
              {26'd0, e.d, e.i, e.l});
      end
    end
  end

  task automatic clear_rf();
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
  endtask

  // Expected dump: non-zero payload only at registers 1, 5 and 31
  task automatic push_dump(input logic [31:0] d1, input logic [31:0] d5,
                           input logic [31:0] d31);
    beat_t b;
    for (int i = 0; i < 32; i++) begin
      b.d = (i == 1) ? d1 : (i == 5) ? d5 : (i == 31) ? d31 : 32'h0;
      b.i = 5'(i);
`ifdef REGDUMP_CHECKSUM_EN
      b.l = 1'b0;
`else
      b.l = (i == 31);
`endif
      exp_q.push_back(b);
    end
`ifdef REGDUMP_CHECKSUM_EN
    b.d = d1 ^ d5 ^ d31;
    b.i = 5'd0;
    b.l = 1'b1;
    exp_q.push_back(b);
`endif
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    for (n = 0; n < 400; n++) begin
      @(negedge clk);
      if (done) break;
    end
    check({name, "_done_seen"}, done, 1);
    repeat (3) @(negedge clk);
    check({name, "_done_cnt"}, done_cnt, 1);
    check({name, "_beats"}, beat_cnt, n_beats);
    check({name, "_q_empty"}, exp_q.size(), 0);
    check({name, "_busy_low"}, busy, 0);
  endtask

  task automatic new_test();
    exp_q.delete();
    beat_cnt = 0;
    done_cnt = 0;
  endtask

  initial begin
`ifdef REGDUMP_CHECKSUM_EN
    n_beats = 33;
`else
    n_beats = 32;
`endif
    clear_rf();
    rst = 1'b0;
    start = 1'b0;
    dump_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", dump_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_outs", {dump_data, dump_index, dump_last, rf_read_addr}, 0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_no_start_busy", busy, 0);

    // All-zero register file, sink always ready
    new_test();
    push_dump(32'h0, 32'h0, 32'h0);
    pulse_start();
    wait_done("zero");

    // R0 garbage must read as zero; R1/R31 patterns
    new_test();
    rf[0] = 32'hFFFF_FFFF;
    rf[1] = 32'hF0F0_F0F0;
    rf[31] = 32'h0F0F_0F0F;
    push_dump(32'hF0F0_F0F0, 32'h0, 32'h0F0F_0F0F);
    pulse_start();
    wait_done("pattern");

    // Backpressure for 7 cycles on beat 5
    new_test();
    clear_rf();
    rf[5] = 32'h5555_AAAA;
    push_dump(32'h0, 32'h5555_AAAA, 32'h0);
    pulse_start();
    begin
      int seen = 0;
      for (int n = 0; n < 200 && seen == 0; n++) begin
        @(posedge clk); #1;
        if (dump_valid && dump_index == 5'd5) seen = 1;
      end
      check("stall_reach5", seen, 1);
      dump_ready = 1'b0;
      for (int s = 0; s < 7; s++) begin
        @(posedge clk); #1;
        check("stall_hold", {dump_valid, dump_index, dump_data},
              {1'b1, 5'd5, 32'h5555_AAAA});
      end
      dump_ready = 1'b1;
    end
    wait_done("stall");

    // Reset during beat 10
    new_test();
    clear_rf();
    push_dump(32'h0, 32'h0, 32'h0);
    pulse_start();
    begin
      int seen = 0;
      for (int n = 0; n < 200 && seen == 0; n++) begin
        @(posedge clk); #1;
        if (dump_valid && dump_index == 5'd10) seen = 1;
      end
      check("rst_reach10", seen, 1);
    end
    rst = 1'b0;
    #1;
    check("midrst_valid", dump_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_outs", {dump_data, dump_index, rf_read_addr}, 0);
    check("midrst_beats", beat_cnt, 10);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("post_rst_quiet", {busy, 6'(beat_cnt)}, {1'b0, 6'd10});
    new_test();
    push_dump(32'h0, 32'h0, 32'h0);
    pulse_start();
    wait_done("redump");

    // Start pulses while busy are ignored
    new_test();
    rf[1] = 32'h1234_5678;
    push_dump(32'h1234_5678, 32'h0, 32'h0);
    pulse_start();
    repeat (4) @(posedge clk);
    pulse_start();
    repeat (30) @(posedge clk);
    pulse_start();
    wait_done("busy_start");
    repeat (5) @(posedge clk);
    #1;
    check("busy_start_idle", {busy, dump_valid}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
